// File: rtl/lcd_bus_scheduler.sv
// lcd_bus_scheduler: arbitrates byte writes from two requesters onto a shared
// HD44780-style LCD bus and turns each granted byte into a timed write cycle
// (setup, enable pulse, controller execution wait).
module lcd_bus_scheduler #(
  parameter int SETUP_CYC     = 2,
  parameter int E_HIGH_CYC    = 12,
  parameter int EXEC_CYC      = 960,
  parameter int LONG_EXEC_CYC = 39360
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [1:0]  req_rs,
  input  logic [15:0] req_data,
  input  logic [1:0]  lock,
  output logic [1:0]  ack,
  output logic        busy,
  output logic        owner,
  output logic [7:0]  d,
  output logic        e,
  output logic        rs
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] PULSE = 2'd2;
  localparam logic [1:0] EXEC  = 2'd3;

  logic [1:0]  state;
  logic [31:0] cnt;
  logic        grant;
  logic        long_cmd;

  // Pick the requester to serve: a locked owner keeps the bus, a lone
  // requester wins outright, and contention alternates away from the owner.
  always_comb begin
    grant = ~owner;
    if (lock[owner] && req[owner]) begin
      grant = owner;
    end else if (req == 2'b01) begin
      grant = 1'b0;
    end else if (req == 2'b10) begin
      grant = 1'b1;
    end
  end

  // Clear (0x01) and return-home (0x02/0x03) commands need the long wait.
  assign long_cmd = !rs && (((d[7:1] == 7'h00) && d[0]) || (d[7:1] == 7'h01));

  // Enable is high only during the pulse; any non-idle state is a busy bus.
  assign e    = (state == PULSE);
  assign busy = (state != IDLE);

  // Write-cycle sequencer: grant/capture in IDLE, then count through the
  // three timed phases, each lasting exactly its configured cycle count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      ack   <= 2'b00;
      owner <= 1'b1;
      d     <= 8'h00;
      rs    <= 1'b0;
    end else begin
      ack <= 2'b00;
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            d     <= grant ? req_data[15:8] : req_data[7:0];
            rs    <= req_rs[grant];
            owner <= grant;
            ack   <= grant ? 2'b10 : 2'b01;
            cnt   <= 32'(SETUP_CYC - 1);
            state <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == 32'd0) begin
            cnt   <= 32'(E_HIGH_CYC - 1);
            state <= PULSE;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        PULSE: begin
          if (cnt == 32'd0) begin
            cnt   <= long_cmd ? 32'(LONG_EXEC_CYC - 1) : 32'(EXEC_CYC - 1);
            state <= EXEC;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        EXEC: begin
          if (cnt == 32'd0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// tb_lcd_bus_scheduler: directed scenarios for the LCD bus scheduler, checked
// each cycle against a timeline model plus literal per-scenario expectations.
module tb_lcd_bus_scheduler;

  localparam int S  = 2;
  localparam int EH = 3;
  localparam int EX = 5;
  localparam int LX = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [1:0]  req_rs = 2'b00;
  logic [15:0] req_data = 16'h0000;
  logic [1:0]  lock = 2'b00;
  logic [1:0]  ack;
  logic        busy;
  logic        owner;
  logic [7:0]  d;
  logic        e;
  logic        rs;

  int checks = 0;
  int failures = 0;

  lcd_bus_scheduler #(
    .SETUP_CYC(S), .E_HIGH_CYC(EH), .EXEC_CYC(EX), .LONG_EXEC_CYC(LX)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_rs(req_rs), .req_data(req_data),
    .lock(lock), .ack(ack), .busy(busy), .owner(owner), .d(d), .e(e), .rs(rs)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: each grant fixes the cycle of ack, the e window and the
  // end of busy from plain arithmetic on the configured phase lengths.
  int          cyc = 0;
  int          m_k = -1000;
  int          m_end = -1000;
  int          m_g = 0;
  logic [7:0]  m_d = 8'h00;
  logic        m_rs = 1'b0;
  logic        m_owner = 1'b1;
  logic [1:0]  s_req, s_lock, s_rs;
  logic [15:0] s_data;
  logic        s_rst;
  logic [1:0]  x_ack;
  logic        x_busy, x_e;

  // Sample inputs at each rising edge, advance the model, compare after settle.
  always begin
    @(posedge clk);
    cyc++;
    s_req = req; s_lock = lock; s_rs = req_rs; s_data = req_data; s_rst = reset;
    #1;
    if (!s_rst) begin
      m_k = -1000; m_end = -1000; m_d = 8'h00; m_rs = 1'b0; m_owner = 1'b1;
    end else if (cyc > m_end && s_req != 2'b00) begin
      if (s_req[m_owner] && s_lock[m_owner]) m_g = m_owner ? 1 : 0;
      else if (s_req == 2'b11) m_g = m_owner ? 0 : 1;
      else m_g = s_req[1] ? 1 : 0;
      m_k = cyc;
      m_d = s_data[8*m_g +: 8];
      m_rs = s_rs[m_g];
      m_owner = (m_g == 1);
      m_end = cyc + S + EH + ((!m_rs && m_d >= 8'd1 && m_d <= 8'd3) ? LX : EX);
    end
    x_ack  = (cyc == m_k) ? (2'b01 << m_g) : 2'b00;
    x_busy = (cyc >= m_k) && (cyc < m_end);
    x_e    = (cyc >= m_k + S) && (cyc < m_k + S + EH);
    check_output("model_ack", 32'(ack), 32'(x_ack));
    check_output("model_busy", 32'(busy), 32'(x_busy));
    check_output("model_e", 32'(e), 32'(x_e));
    check_output("model_d", 32'(d), 32'(m_d));
    check_output("model_rs", 32'(rs), 32'(m_rs));
    check_output("model_owner", 32'(owner), 32'(m_owner));
    check_output("ack_onehot", 32'($countones(ack) <= 1), 32'd1);
    check_output("ack_not_with_e", 32'((ack != 2'b00) && e), 32'd0);
  end

  task automatic wait_ack(output int idx, output logic [7:0] dv);
    idx = -1;
    dv = 8'h00;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (ack != 2'b00) begin
        idx = ack[1] ? 1 : 0;
        dv = d;
        return;
      end
    end
    check_output("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(output int n);
    n = 1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (!busy) return;
      n++;
    end
    check_output("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0; req = 2'b00; lock = 2'b00;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  logic [7:0] r1_bytes [3];
  logic [7:0] t5_data [5];
  logic       t5_rs [5];
  int         t5_len [5];

  // Directed scenarios with hand-computed expectations.
  initial begin
    int idx;
    int n;
    logic [7:0] dv;
    r1_bytes = '{8'h43, 8'h34, 8'h20};
    t5_data  = '{8'h01, 8'h02, 8'h03, 8'h38, 8'h01};
    t5_rs    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    t5_len   = '{25, 25, 25, 10, 10};

    // Scenario 1: reset for three cycles, then idle with no requests.
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_output("s1_d", 32'(d), 32'h00);
      check_output("s1_rs", 32'(rs), 32'd0);
      check_output("s1_e", 32'(e), 32'd0);
      check_output("s1_busy", 32'(busy), 32'd0);
      check_output("s1_ack", 32'(ack), 32'd0);
      check_output("s1_owner", 32'(owner), 32'd1);
    end

    // Scenario 2: single data write 0x41, then a held request for 0x42.
    @(negedge clk);
    req_data = 16'h0041; req_rs = 2'b01; req = 2'b01;
    wait_ack(idx, dv);
    check_output("s2_idx", 32'(idx), 32'd0);
    check_output("s2_d", 32'(dv), 32'h41);
    check_output("s2_rs", 32'(rs), 32'd1);
    check_output("s2_ack", 32'(ack), 32'b01);
    check_output("s2_busy0", 32'(busy), 32'd1);
    req_data = 16'h0042;
    for (int i = 1; i <= 11; i++) begin
      @(posedge clk); #1;
      check_output("s2_e", 32'(e), 32'(i >= 2 && i <= 4));
      check_output("s2_busy", 32'(busy), 32'(i < 10 || i == 11));
      if (i == 10) check_output("s2_ack_gap", 32'(ack), 32'd0);
      if (i == 11) begin
        check_output("s2_next_ack", 32'(ack), 32'b01);
        check_output("s2_next_d", 32'(d), 32'h42);
        req = 2'b00;
      end
    end
    wait_idle(n);

    // Scenario 3: contention from reset alternates 0,1,0,1.
    apply_reset();
    @(negedge clk);
    req_data = 16'hB1A0; req_rs = 2'b00; req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_ack(idx, dv);
      check_output("s3_idx", 32'(idx), 32'(i % 2));
      check_output("s3_d", 32'(dv), (i % 2 == 1) ? 32'hB1 : 32'hA0);
      check_output("s3_owner", 32'(owner), 32'(i % 2));
    end
    req = 2'b00;
    wait_idle(n);

    // Scenario 4: requester 1 locks the bus for three bytes.
    @(negedge clk);
    req_data = {8'h43, 8'h30}; req_rs = 2'b10; lock = 2'b10; req = 2'b11;
    for (int j = 0; j < 3; j++) begin
      wait_ack(idx, dv);
      check_output("s4_idx", 32'(idx), 32'd1);
      check_output("s4_d", 32'(dv), 32'(r1_bytes[j]));
      if (j < 2) req_data[15:8] = r1_bytes[j+1];
      else begin lock = 2'b00; req = 2'b01; end
    end
    wait_ack(idx, dv);
    check_output("s4_after_idx", 32'(idx), 32'd0);
    check_output("s4_after_d", 32'(dv), 32'h30);
    check_output("s4_after_rs", 32'(rs), 32'd0);
    req = 2'b00;
    wait_idle(n);

    // Scenario 5: long execution for clear/home commands only.
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      req_data = {8'h00, t5_data[t]}; req_rs = {1'b0, t5_rs[t]}; req = 2'b01;
      wait_ack(idx, dv);
      req = 2'b00;
      check_output("s5_d", 32'(dv), 32'(t5_data[t]));
      wait_idle(n);
      check_output("s5_busy_len", 32'(n), 32'(t5_len[t]));
    end

    // Scenario 6: asynchronous reset mid-pulse, then a clean write.
    @(negedge clk);
    req_data = 16'h0055; req_rs = 2'b00; req = 2'b01;
    wait_ack(idx, dv);
    req = 2'b00;
    repeat (3) @(posedge clk);
    #4;
    check_output("s6_pre_e", 32'(e), 32'd1);
    reset = 1'b0;
    #1;
    check_output("s6_e", 32'(e), 32'd0);
    check_output("s6_busy", 32'(busy), 32'd0);
    check_output("s6_d", 32'(d), 32'h00);
    check_output("s6_ack", 32'(ack), 32'd0);
    check_output("s6_owner", 32'(owner), 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_output("s6_no_stale_ack", 32'(ack), 32'd0);
      check_output("s6_idle", 32'(busy), 32'd0);
    end
    @(negedge clk);
    req_data = 16'h0066; req_rs = 2'b00; req = 2'b01;
    wait_ack(idx, dv);
    req = 2'b00;
    check_output("s6_new_idx", 32'(idx), 32'd0);
    check_output("s6_new_d", 32'(dv), 32'h66);
    wait_idle(n);
    check_output("s6_new_len", 32'(n), 32'd10);

    repeat (2) @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
